// File: rtl/ctr_step_pkg.sv
// Shared types and seven-segment helpers for the step-size selector.
// Segment encoding is active-low, bit order {g,f,e,d,c,b,a}.
package ctr_step_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   typedef struct packed {
      logic up;
      logic dn;
      logic sign;
   } btn_pulse_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
      logic [6:0] w_seg;
      case (i_nib)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         default: w_seg = 7'h0E;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/ctr_step_select_btn_sync_pulse.sv
// Button conditioner: 2-flop synchroniser, falling-edge pulse and optional hold-to-repeat.
// Repeat logic is built only when CTR_STEP_AUTO_REPEAT_EN is defined and REPEAT_ON = 1.
module btn_sync_pulse
   import ctr_step_pkg::*;
#(
   parameter bit REPEAT_ON  = 1'b1,
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_PER = 5000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic [1:0] r_rdy;
   logic r_armed;
   logic r_pulse;
   logic w_held;
   logic w_fire;

   // r_armed blocks a pulse from a button already held through reset:
   // only a real high sample followed by a low one counts as a press.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_s3    <= 1'b1;
         r_rdy   <= 2'b00;
         r_armed <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         r_rdy   <= {r_rdy[0], 1'b1};
         r_armed <= r_armed | (r_rdy[1] & r_s2);
         r_pulse <= (r_armed & r_s3 & ~r_s2) | w_fire;
      end
   end

   assign w_held  = r_armed & ~r_s2 & i_en;
   assign o_pulse = r_pulse;

`ifdef CTR_STEP_AUTO_REPEAT_EN
   if (REPEAT_ON) begin : g_rpt
      logic [CNT_W-1:0] r_cnt;
      logic             r_run;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
         end else if (!w_held) begin
            r_cnt <= '0;
            r_run <= 1'b0;
         end else if (!r_run) begin
            r_cnt <= CNT_W'(REPEAT_DLY - 1);
            r_run <= 1'b1;
         end else if (r_cnt == '0) begin
            r_cnt <= CNT_W'(REPEAT_PER - 1);
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end

      assign w_fire = w_held & r_run & (r_cnt == '0);
   end else begin : g_no_rpt
      logic w_unused;
      assign w_unused = w_held & (CNT_W > 0);
      assign w_fire   = 1'b0;
   end
`else
   logic w_unused;
   assign w_unused = w_held & REPEAT_ON & (CNT_W > 0);
   assign w_fire   = 1'b0;
`endif

endmodule

// File: rtl/ctr_step_select.sv
// Signed power-of-ratio step selector with up/dn/sign buttons and 3-digit display.
// Optional hold-to-repeat on up/dn: define CTR_STEP_AUTO_REPEAT_EN.
module ctr_step_select
   import ctr_step_pkg::*;
#(
   parameter int STEP_W     = 8,
   parameter int NUM_LEVELS = 4,
   parameter int LOG2_RATIO = 2,
   parameter int WRAP       = 1,
   parameter int SEG_W      = 7,
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_PER = 5000000
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_en,
   input  logic                           i_btn_up,
   input  logic                           i_btn_dn,
   input  logic                           i_btn_sign,
   output logic signed [STEP_W-1:0]       o_step,
   output logic [$clog2(NUM_LEVELS)-1:0]  o_level,
   output logic                           o_neg,
   output logic [SEG_W-1:0]               o_hex_0,
   output logic [SEG_W-1:0]               o_hex_1,
   output logic [SEG_W-1:0]               o_hex_2
);

   localparam int               LVL_W   = $clog2(NUM_LEVELS);
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
   localparam int               MAG_W   = (STEP_W > 8) ? STEP_W : 8;

   btn_pulse_t w_pulse;

   btn_sync_pulse #(.REPEAT_ON(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_btn_up (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_btn   (i_btn_up),
      .o_pulse (w_pulse.up)
   );

   btn_sync_pulse #(.REPEAT_ON(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_btn_dn (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_btn   (i_btn_dn),
      .o_pulse (w_pulse.dn)
   );

   btn_sync_pulse #(.REPEAT_ON(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_btn_sign (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_btn   (i_btn_sign),
      .o_pulse (w_pulse.sign)
   );

   logic [LVL_W-1:0]  r_level;
   logic              r_neg;
   logic [STEP_W-1:0] r_step;
   logic [SEG_W-1:0]  r_hex_0;
   logic [SEG_W-1:0]  r_hex_1;
   logic [SEG_W-1:0]  r_hex_2;

   logic [LVL_W-1:0]  w_level_nxt;
   logic              w_neg_nxt;
   logic [STEP_W-1:0] w_mag_nxt;
   logic [STEP_W-1:0] w_step_nxt;
   logic [MAG_W-1:0]  w_mag_disp;

   always_comb begin
      w_level_nxt = r_level;
      w_neg_nxt   = r_neg;
      if (i_en) begin
         w_neg_nxt = r_neg ^ w_pulse.sign;
         if (w_pulse.up && !w_pulse.dn) begin
            if (r_level == LVL_MAX)
               w_level_nxt = (WRAP != 0) ? '0 : LVL_MAX;
            else
               w_level_nxt = r_level + LVL_W'(1);
         end else if (w_pulse.dn && !w_pulse.up) begin
            if (r_level == '0)
               w_level_nxt = (WRAP != 0) ? LVL_MAX : '0;
            else
               w_level_nxt = r_level - LVL_W'(1);
         end
      end
   end

   // Step is computed from next-state level/sign so it updates on the same edge.
   assign w_mag_nxt  = STEP_W'(1) << (LOG2_RATIO * w_level_nxt);
   assign w_step_nxt = w_neg_nxt ? (~w_mag_nxt + STEP_W'(1)) : w_mag_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_level <= '0;
         r_neg   <= 1'b0;
         r_step  <= STEP_W'(1);
      end else begin
         r_level <= w_level_nxt;
         r_neg   <= w_neg_nxt;
         r_step  <= w_step_nxt;
      end
   end

   // Display trails the step register by one cycle.
   assign w_mag_disp = MAG_W'(1) << (LOG2_RATIO * r_level);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hex_0 <= SEG_W'(SEG_BLANK);
         r_hex_1 <= SEG_W'(hex_to_seg(4'h1));
         r_hex_2 <= SEG_W'(hex_to_seg(4'h0));
      end else begin
         r_hex_0 <= r_neg ? SEG_W'(SEG_MINUS) : SEG_W'(SEG_BLANK);
         r_hex_1 <= SEG_W'(hex_to_seg(w_mag_disp[3:0]));
         r_hex_2 <= SEG_W'(hex_to_seg(w_mag_disp[7:4]));
      end
   end

   assign o_step  = r_step;
   assign o_level = r_level;
   assign o_neg   = r_neg;
   assign o_hex_0 = r_hex_0;
   assign o_hex_1 = r_hex_1;
   assign o_hex_2 = r_hex_2;

endmodule
